// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one byte-wide RAM port between the instruction cache
// (IC) and the data cache (DC). Each transaction is broken into byte accesses.
// Read bytes are assembled into a little-endian 32-bit word. Completion is
// signalled with a one-cycle done pulse. DC has fixed priority over IC, and a
// granted transaction runs to completion.
//
// Optional feature macro: IO_STALL_EN. When it is defined, a write byte aimed
// at the IO region waits while io_buffer_full is high. When it is undefined,
// io_buffer_full is ignored.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   en                  global ready; low freezes all state
//   ic_req_en/add       IC 4-byte read request pulse and byte address
//   ic_done/ic_dat      IC completion pulse and assembled word
//   dc_req_en/rw/len/add/dat  DC request pulse and payload
//   dc_done/dc_dat      DC completion pulse and read data (0 for writes)
//   mem_din             RAM read byte, valid the cycle after its address
//   mem_dout/mem_a/mem_wr  RAM write byte, byte address, write strobe
//   io_buffer_full      IO output buffer full
module mem_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned IO_BIT = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              ic_req_en,
  input  logic [ADDR_W-1:0] ic_req_add,
  output logic              ic_done,
  output logic [31:0]       ic_dat,
  input  logic              dc_req_en,
  input  logic              dc_req_rw,
  input  logic [2:0]        dc_req_len,
  input  logic [ADDR_W-1:0] dc_req_add,
  input  logic [31:0]       dc_req_dat,
  output logic              dc_done,
  output logic [31:0]       dc_dat,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  input  logic              io_buffer_full
);

  localparam int unsigned CNT_W  = 3;
  localparam int unsigned WORD_W = 32;

  typedef enum logic [2:0] {IDLE, DC_RD, DC_WR, IC_RD, STALL} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   base;
  logic [CNT_W-1:0]    len;
  logic [CNT_W-1:0]    cnt;
  logic [WORD_W-1:0]   wdat;
  logic [WORD_W-1:0]   asm_q;
  logic                mem_wr_q;

  logic                dc_pend;
  logic                dc_p_rw;
  logic [CNT_W-1:0]    dc_p_len;
  logic [ADDR_W-1:0]   dc_p_add;
  logic [WORD_W-1:0]   dc_p_dat;
  logic                ic_pend;
  logic [ADDR_W-1:0]   ic_p_add;

  // Length 0 behaves as 1; anything above 4 behaves as 4.
  function automatic logic [CNT_W-1:0] norm_len(input logic [2:0] l);
    if (l == 3'd0)      return 3'd1;
    else if (l > 3'd4)  return 3'd4;
    else                return l;
  endfunction

  function automatic logic is_io(input logic [ADDR_W-1:0] a);
    return a[IO_BIT -: 2] == 2'b11;
  endfunction

  function automatic logic [7:0] byte_of(input logic [WORD_W-1:0] w,
                                         input logic [CNT_W-1:0]  k);
    return w[{k[1:0], 3'b000} +: 8];
  endfunction

  logic                dc_busy, ic_busy;
  logic                dc_take, ic_take;
  logic                dc_avail, ic_avail;
  logic                dc_rw_eff;
  logic [CNT_W-1:0]    dc_len_eff;
  logic [ADDR_W-1:0]   dc_add_eff, ic_add_eff;
  logic [WORD_W-1:0]   dc_dat_eff;
  logic                rd_fin, wr_fin, free;
  logic                grant_dc, grant_ic;
  logic [CNT_W-1:0]    cnt_p1, cnt_m1;
  logic [ADDR_W-1:0]   add_cur, add_nxt;
  logic                io_first, io_nxt;
  logic                stall_first, stall_nxt, stall_hold;
  logic [WORD_W-1:0]   asm_nx;
  state_t              st_state;
  logic [ADDR_W-1:0]   st_a;
  logic [7:0]          st_dout;
  logic                st_wr;

  // A requester that is pending or in service ignores further pulses.
  assign dc_busy  = (state == DC_RD) || (state == DC_WR) || (state == STALL);
  assign ic_busy  = (state == IC_RD);
  assign dc_take  = dc_req_en && !dc_pend && !dc_busy;
  assign ic_take  = ic_req_en && !ic_pend && !ic_busy;
  assign dc_avail = dc_pend || dc_take;
  assign ic_avail = ic_pend || ic_take;

  // A fresh pulse can be granted on the same edge it is sampled.
  assign dc_rw_eff  = dc_pend ? dc_p_rw  : dc_req_rw;
  assign dc_len_eff = dc_pend ? dc_p_len : norm_len(dc_req_len);
  assign dc_add_eff = dc_pend ? dc_p_add : dc_req_add;
  assign dc_dat_eff = dc_pend ? dc_p_dat : dc_req_dat;
  assign ic_add_eff = ic_pend ? ic_p_add : ic_req_add;

  assign cnt_p1  = cnt + 3'd1;
  assign cnt_m1  = cnt - 3'd1;
  assign add_cur = base + ADDR_W'(cnt);
  assign add_nxt = base + ADDR_W'(cnt_p1);

  // Read finishes on the capture of its last byte; write on its last issue.
  assign rd_fin   = ((state == DC_RD) || (state == IC_RD)) && (cnt == len);
  assign wr_fin   = (state == DC_WR) && (cnt_p1 == len);
  assign free     = (state == IDLE) || rd_fin || wr_fin;
  assign grant_dc = free && dc_avail;
  assign grant_ic = free && !dc_avail && ic_avail;

  assign io_first = is_io(dc_add_eff);
  assign io_nxt   = is_io(add_nxt);

`ifdef IO_STALL_EN
  assign stall_first = io_first && io_buffer_full;
  assign stall_nxt   = io_nxt && io_buffer_full;
  assign stall_hold  = io_buffer_full;
`else
  assign stall_first = 1'b0;
  assign stall_nxt   = 1'b0;
  assign stall_hold  = 1'b0;
  logic unused_io;
  assign unused_io = io_buffer_full ^ io_first ^ io_nxt;
`endif

  // Byte captured this cycle belongs to the address issued one cycle earlier.
  always_comb begin
    asm_nx = asm_q;
    if (cnt != '0) asm_nx[{cnt_m1[1:0], 3'b000} +: 8] = mem_din;
  end

  // Next state and first-cycle outputs when a new transaction is granted.
  always_comb begin
    st_state = IDLE;
    st_a     = '0;
    st_dout  = '0;
    st_wr    = 1'b0;
    if (grant_dc) begin
      if (dc_rw_eff) begin
        if (stall_first) begin
          st_state = STALL;
        end else begin
          st_state = DC_WR;
          st_a     = dc_add_eff;
          st_dout  = dc_dat_eff[7:0];
          st_wr    = 1'b1;
        end
      end else begin
        st_state = DC_RD;
        st_a     = dc_add_eff;
      end
    end else if (grant_ic) begin
      st_state = IC_RD;
      st_a     = ic_add_eff;
    end
  end

  // FSM, request latching and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      base     <= '0;
      len      <= '0;
      cnt      <= '0;
      wdat     <= '0;
      asm_q    <= '0;
      mem_wr_q <= 1'b0;
      mem_a    <= '0;
      mem_dout <= '0;
      ic_done  <= 1'b0;
      ic_dat   <= '0;
      dc_done  <= 1'b0;
      dc_dat   <= '0;
      dc_pend  <= 1'b0;
      dc_p_rw  <= 1'b0;
      dc_p_len <= '0;
      dc_p_add <= '0;
      dc_p_dat <= '0;
      ic_pend  <= 1'b0;
      ic_p_add <= '0;
    end else if (en) begin
      ic_done <= 1'b0;
      dc_done <= 1'b0;

      dc_pend <= dc_avail && !grant_dc;
      ic_pend <= ic_avail && !grant_ic;
      if (dc_take) begin
        dc_p_rw  <= dc_req_rw;
        dc_p_len <= norm_len(dc_req_len);
        dc_p_add <= dc_req_add;
        dc_p_dat <= dc_req_dat;
      end
      if (ic_take) ic_p_add <= ic_req_add;

      case (state)
        IDLE: begin
          state    <= st_state;
          mem_a    <= st_a;
          mem_dout <= st_dout;
          mem_wr_q <= st_wr;
        end
        DC_RD, IC_RD: begin
          asm_q <= asm_nx;
          if (rd_fin) begin
            if (state == DC_RD) begin
              dc_done <= 1'b1;
              dc_dat  <= asm_nx;
            end else begin
              ic_done <= 1'b1;
              ic_dat  <= asm_nx;
            end
            state    <= st_state;
            mem_a    <= st_a;
            mem_dout <= st_dout;
            mem_wr_q <= st_wr;
          end else begin
            cnt      <= cnt_p1;
            mem_a    <= (cnt_p1 < len) ? add_nxt : '0;
            mem_dout <= '0;
            mem_wr_q <= 1'b0;
          end
        end
        DC_WR: begin
          if (wr_fin) begin
            dc_done  <= 1'b1;
            dc_dat   <= '0;
            state    <= st_state;
            mem_a    <= st_a;
            mem_dout <= st_dout;
            mem_wr_q <= st_wr;
          end else begin
            cnt <= cnt_p1;
            if (stall_nxt) begin
              state    <= STALL;
              mem_a    <= '0;
              mem_dout <= '0;
              mem_wr_q <= 1'b0;
            end else begin
              mem_a    <= add_nxt;
              mem_dout <= byte_of(wdat, cnt_p1);
              mem_wr_q <= 1'b1;
            end
          end
        end
        STALL: begin
          // Counter already points at the waiting byte.
          if (!stall_hold) begin
            state    <= DC_WR;
            mem_a    <= add_cur;
            mem_dout <= byte_of(wdat, cnt);
            mem_wr_q <= 1'b1;
          end else begin
            mem_a    <= '0;
            mem_dout <= '0;
            mem_wr_q <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          mem_a    <= '0;
          mem_dout <= '0;
          mem_wr_q <= 1'b0;
        end
      endcase

      if (grant_dc || grant_ic) begin
        base  <= grant_dc ? dc_add_eff : ic_add_eff;
        len   <= grant_dc ? dc_len_eff : 3'd4;
        wdat  <= dc_dat_eff;
        cnt   <= '0;
        asm_q <= '0;
      end
    end
  end

  assign mem_wr = mem_wr_q & en;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter. The RAM model returns the byte at the
// previous cycle's address. The model is gated by en, because en freezes the
// whole memory system.
module tb_mem_arbiter;

  localparam int unsigned ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic              ic_req_en;
  logic [ADDR_W-1:0] ic_req_add;
  logic              ic_done;
  logic [31:0]       ic_dat;
  logic              dc_req_en;
  logic              dc_req_rw;
  logic [2:0]        dc_req_len;
  logic [ADDR_W-1:0] dc_req_add;
  logic [31:0]       dc_req_dat;
  logic              dc_done;
  logic [31:0]       dc_dat;
  logic [7:0]        mem_din;
  logic [7:0]        mem_dout;
  logic [ADDR_W-1:0] mem_a;
  logic              mem_wr;
  logic              io_buffer_full;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] ram [0:1023];

  mem_arbiter #(.ADDR_W(ADDR_W), .IO_BIT(17)) dut (
    .clk(clk), .rst(rst), .en(en),
    .ic_req_en(ic_req_en), .ic_req_add(ic_req_add),
    .ic_done(ic_done), .ic_dat(ic_dat),
    .dc_req_en(dc_req_en), .dc_req_rw(dc_req_rw), .dc_req_len(dc_req_len),
    .dc_req_add(dc_req_add), .dc_req_dat(dc_req_dat),
    .dc_done(dc_done), .dc_dat(dc_dat),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (en) mem_din <= ram[mem_a[9:0]];

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) step();
    @(negedge clk);
    n_cmp++; if (mem_a !== '0)   begin n_bad++; $display("FAIL reset mem_a: got %h want 0", mem_a); end
    n_cmp++; if (mem_wr !== 1'b0) begin n_bad++; $display("FAIL reset mem_wr: got %b want 0", mem_wr); end
    n_cmp++; if (mem_dout !== 8'h0) begin n_bad++; $display("FAIL reset mem_dout: got %h want 0", mem_dout); end
    n_cmp++; if (ic_done !== 1'b0) begin n_bad++; $display("FAIL reset ic_done: got %b want 0", ic_done); end
    n_cmp++; if (dc_done !== 1'b0) begin n_bad++; $display("FAIL reset dc_done: got %b want 0", dc_done); end
    n_cmp++; if (ic_dat !== 32'h0) begin n_bad++; $display("FAIL reset ic_dat: got %h want 0", ic_dat); end
    n_cmp++; if (dc_dat !== 32'h0) begin n_bad++; $display("FAIL reset dc_dat: got %h want 0", dc_dat); end
    step();
    rst = 1'b0;
  endtask

  task automatic test_dc_read;
    logic [31:0] ea [0:6];
    ea = '{32'h0, 32'h100, 32'h101, 32'h102, 32'h103, 32'h0, 32'h0};
    dc_req_en = 1'b1; dc_req_rw = 1'b0; dc_req_len = 3'd4;
    dc_req_add = 32'h100; dc_req_dat = 32'h0;
    for (int c = 0; c <= 6; c++) begin
      @(negedge clk);
      n_cmp++; if (mem_a !== ea[c]) begin n_bad++; $display("FAIL dc_read mem_a c%0d: got %h want %h", c, mem_a, ea[c]); end
      n_cmp++; if (mem_wr !== 1'b0) begin n_bad++; $display("FAIL dc_read mem_wr c%0d: got %b want 0", c, mem_wr); end
      n_cmp++; if (dc_done !== 1'(c == 6)) begin n_bad++; $display("FAIL dc_read dc_done c%0d: got %b want %b", c, dc_done, c == 6); end
      if (c == 6) begin
        n_cmp++; if (dc_dat !== 32'h44332211) begin n_bad++; $display("FAIL dc_read dc_dat: got %h want 44332211", dc_dat); end
      end
      step();
      dc_req_en = 1'b0;
    end
  endtask

  task automatic test_dc_write;
    logic [31:0] ea [0:3];
    logic [7:0]  ed [0:3];
    logic [3:0]  ewr;
    ea  = '{32'h0, 32'h200, 32'h201, 32'h0};
    ed  = '{8'h00, 8'hEF, 8'hBE, 8'h00};
    ewr = 4'b0110;
    dc_req_en = 1'b1; dc_req_rw = 1'b1; dc_req_len = 3'd2;
    dc_req_add = 32'h200; dc_req_dat = 32'hDEADBEEF;
    for (int c = 0; c <= 3; c++) begin
      @(negedge clk);
      n_cmp++; if (mem_a !== ea[c]) begin n_bad++; $display("FAIL dc_write mem_a c%0d: got %h want %h", c, mem_a, ea[c]); end
      n_cmp++; if (mem_wr !== ewr[c]) begin n_bad++; $display("FAIL dc_write mem_wr c%0d: got %b want %b", c, mem_wr, ewr[c]); end
      n_cmp++; if (mem_dout !== ed[c]) begin n_bad++; $display("FAIL dc_write mem_dout c%0d: got %h want %h", c, mem_dout, ed[c]); end
      n_cmp++; if (dc_done !== 1'(c == 3)) begin n_bad++; $display("FAIL dc_write dc_done c%0d: got %b want %b", c, dc_done, c == 3); end
      if (c == 3) begin
        n_cmp++; if (dc_dat !== 32'h0) begin n_bad++; $display("FAIL dc_write dc_dat: got %h want 0", dc_dat); end
      end
      step();
      dc_req_en = 1'b0;
    end
  endtask

  task automatic test_simultaneous;
    logic [31:0] ea [0:8];
    ea = '{32'h0, 32'h80, 32'h0, 32'h0, 32'h1, 32'h2, 32'h3, 32'h0, 32'h0};
    ic_req_en = 1'b1; ic_req_add = 32'h0;
    dc_req_en = 1'b1; dc_req_rw = 1'b0; dc_req_len = 3'd1; dc_req_add = 32'h80;
    for (int c = 0; c <= 8; c++) begin
      @(negedge clk);
      n_cmp++; if (mem_a !== ea[c]) begin n_bad++; $display("FAIL simul mem_a c%0d: got %h want %h", c, mem_a, ea[c]); end
      n_cmp++; if (dc_done !== 1'(c == 3)) begin n_bad++; $display("FAIL simul dc_done c%0d: got %b want %b", c, dc_done, c == 3); end
      n_cmp++; if (ic_done !== 1'(c == 8)) begin n_bad++; $display("FAIL simul ic_done c%0d: got %b want %b", c, ic_done, c == 8); end
      if (c == 3) begin
        n_cmp++; if (dc_dat !== 32'h0000005A) begin n_bad++; $display("FAIL simul dc_dat: got %h want 0000005a", dc_dat); end
      end
      if (c == 8) begin
        n_cmp++; if (ic_dat !== 32'h04030201) begin n_bad++; $display("FAIL simul ic_dat: got %h want 04030201", ic_dat); end
      end
      step();
      ic_req_en = 1'b0;
      dc_req_en = 1'b0;
    end
  endtask

  task automatic test_io_write;
    logic [31:0] ea [0:7];
    logic [7:0]  ewr;
    logic [7:0]  edone;
    int          last;
`ifdef IO_STALL_EN
    ea    = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h30000, 32'h0};
    ewr   = 8'b0100_0000;
    edone = 8'b1000_0000;
    last  = 7;
`else
    ea    = '{32'h0, 32'h30000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    ewr   = 8'b0000_0010;
    edone = 8'b0000_0100;
    last  = 2;
`endif
    io_buffer_full = 1'b1;
    dc_req_en = 1'b1; dc_req_rw = 1'b1; dc_req_len = 3'd1;
    dc_req_add = 32'h30000; dc_req_dat = 32'h41;
    for (int c = 0; c <= last; c++) begin
      @(negedge clk);
      n_cmp++; if (mem_a !== ea[c]) begin n_bad++; $display("FAIL io_write mem_a c%0d: got %h want %h", c, mem_a, ea[c]); end
      n_cmp++; if (mem_wr !== ewr[c]) begin n_bad++; $display("FAIL io_write mem_wr c%0d: got %b want %b", c, mem_wr, ewr[c]); end
      n_cmp++; if (dc_done !== edone[c]) begin n_bad++; $display("FAIL io_write dc_done c%0d: got %b want %b", c, dc_done, edone[c]); end
      if (ewr[c]) begin
        n_cmp++; if (mem_dout !== 8'h41) begin n_bad++; $display("FAIL io_write mem_dout c%0d: got %h want 41", c, mem_dout); end
      end
      step();
      dc_req_en = 1'b0;
      io_buffer_full = (c + 1 <= 4);
    end
    io_buffer_full = 1'b0;
  endtask

  task automatic test_en_freeze;
    logic [31:0] ea [0:8];
    ea = '{32'h0, 32'h100, 32'h101, 32'h101, 32'h101, 32'h102, 32'h103, 32'h0, 32'h0};
    ic_req_en = 1'b1; ic_req_add = 32'h100;
    for (int c = 0; c <= 8; c++) begin
      @(negedge clk);
      n_cmp++; if (mem_a !== ea[c]) begin n_bad++; $display("FAIL en_freeze mem_a c%0d: got %h want %h", c, mem_a, ea[c]); end
      n_cmp++; if (mem_wr !== 1'b0) begin n_bad++; $display("FAIL en_freeze mem_wr c%0d: got %b want 0", c, mem_wr); end
      n_cmp++; if (ic_done !== 1'(c == 8)) begin n_bad++; $display("FAIL en_freeze ic_done c%0d: got %b want %b", c, ic_done, c == 8); end
      if (c == 8) begin
        n_cmp++; if (ic_dat !== 32'h44332211) begin n_bad++; $display("FAIL en_freeze ic_dat: got %h want 44332211", ic_dat); end
      end
      step();
      ic_req_en = 1'b0;
      en = !((c + 1 == 2) || (c + 1 == 3));
    end
    en = 1'b1;
  endtask

  task automatic test_len_clamp;
    logic [2:0]  lens [0:1];
    logic [31:0] adds [0:1];
    logic [31:0] exps [0:1];
    int          nb   [0:1];
    logic [31:0] exp_a;
    lens = '{3'd0, 3'd7};
    adds = '{32'h100, 32'h104};
    exps = '{32'h00000011, 32'h88776655};
    nb   = '{1, 4};
    for (int k = 0; k < 2; k++) begin
      dc_req_en = 1'b1; dc_req_rw = 1'b0; dc_req_len = lens[k]; dc_req_add = adds[k];
      for (int c = 0; c <= nb[k] + 2; c++) begin
        @(negedge clk);
        exp_a = (c >= 1 && c <= nb[k]) ? adds[k] + 32'(c - 1) : 32'h0;
        n_cmp++; if (mem_a !== exp_a) begin n_bad++; $display("FAIL len_clamp%0d mem_a c%0d: got %h want %h", k, c, mem_a, exp_a); end
        n_cmp++; if (dc_done !== 1'(c == nb[k] + 2)) begin n_bad++; $display("FAIL len_clamp%0d dc_done c%0d: got %b", k, c, dc_done); end
        if (c == nb[k] + 2) begin
          n_cmp++; if (dc_dat !== exps[k]) begin n_bad++; $display("FAIL len_clamp%0d dc_dat: got %h want %h", k, dc_dat, exps[k]); end
        end
        step();
        dc_req_en = 1'b0;
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] ea  [0:8];
    logic [31:0] eia [0:6];
    ea  = '{32'h0, 32'h100, 32'h101, 32'h102, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    eia = '{32'h0, 32'h104, 32'h105, 32'h106, 32'h107, 32'h0, 32'h0};
    dc_req_en = 1'b1; dc_req_rw = 1'b0; dc_req_len = 3'd4; dc_req_add = 32'h100;
    for (int c = 0; c <= 8; c++) begin
      @(negedge clk);
      n_cmp++; if (mem_a !== ea[c]) begin n_bad++; $display("FAIL reset_mid mem_a c%0d: got %h want %h", c, mem_a, ea[c]); end
      n_cmp++; if (dc_done !== 1'b0) begin n_bad++; $display("FAIL reset_mid dc_done c%0d: got %b want 0", c, dc_done); end
      if (c >= 4) begin
        n_cmp++; if (dc_dat !== 32'h0 || ic_dat !== 32'h0 || mem_wr !== 1'b0 || mem_dout !== 8'h0) begin
          n_bad++; $display("FAIL reset_mid outs c%0d: got dc_dat=%h ic_dat=%h wr=%b dout=%h want all 0", c, dc_dat, ic_dat, mem_wr, mem_dout);
        end
      end
      step();
      dc_req_en = 1'b0;
      rst = (c + 1 == 3);
    end
    rst = 1'b0;
    ic_req_en = 1'b1; ic_req_add = 32'h104;
    for (int c = 0; c <= 6; c++) begin
      @(negedge clk);
      n_cmp++; if (mem_a !== eia[c]) begin n_bad++; $display("FAIL reset_mid ic mem_a c%0d: got %h want %h", c, mem_a, eia[c]); end
      n_cmp++; if (ic_done !== 1'(c == 6)) begin n_bad++; $display("FAIL reset_mid ic_done c%0d: got %b want %b", c, ic_done, c == 6); end
      if (c == 6) begin
        n_cmp++; if (ic_dat !== 32'h88776655) begin n_bad++; $display("FAIL reset_mid ic_dat: got %h want 88776655", ic_dat); end
      end
      step();
      ic_req_en = 1'b0;
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
    ram[10'h000] = 8'h01; ram[10'h001] = 8'h02; ram[10'h002] = 8'h03; ram[10'h003] = 8'h04;
    ram[10'h080] = 8'h5A;
    ram[10'h100] = 8'h11; ram[10'h101] = 8'h22; ram[10'h102] = 8'h33; ram[10'h103] = 8'h44;
    ram[10'h104] = 8'h55; ram[10'h105] = 8'h66; ram[10'h106] = 8'h77; ram[10'h107] = 8'h88;

    rst = 1'b1; en = 1'b1;
    ic_req_en = 1'b0; ic_req_add = '0;
    dc_req_en = 1'b0; dc_req_rw = 1'b0; dc_req_len = 3'd0; dc_req_add = '0; dc_req_dat = '0;
    io_buffer_full = 1'b0;
    #1;

    test_reset();
    test_dc_read();
    test_dc_write();
    test_simultaneous();
    test_io_write();
    test_en_freeze();
    test_len_clamp();
    test_reset_mid();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
